// File: rtl/elem_pulse_player_if.sv
// ----------------------------------------------------------------------------
// elem_pulse_player_if
// Command/playback bundle between a pulse sequencer and one element player.
//   master : drives cmdstb + command fields, observes the playback stream
//   slave  : the player; samples command fields, drives the playback stream
// Command  : cmdstb, envstart, envlength, ampx, freqaddr, pini, mode
// Playback : env_addr, env_valid, amp_out, freq_out, phase_out, busy, done, overflow
// ----------------------------------------------------------------------------
interface elem_pulse_player_if #(
    parameter int unsigned ENV_ADDR_WIDTH = 12,
    parameter int unsigned AMP_WIDTH      = 16,
    parameter int unsigned FREQ_WIDTH     = 9,
    parameter int unsigned PHASE_WIDTH    = 17
) ();
    logic                      cmdstb;
    logic [ENV_ADDR_WIDTH-1:0] envstart;
    logic [ENV_ADDR_WIDTH-1:0] envlength;
    logic [AMP_WIDTH-1:0]      ampx;
    logic [FREQ_WIDTH-1:0]     freqaddr;
    logic [PHASE_WIDTH-1:0]    pini;
    logic [1:0]                mode;

    logic [ENV_ADDR_WIDTH-1:0] env_addr;
    logic                      env_valid;
    logic [AMP_WIDTH-1:0]      amp_out;
    logic [FREQ_WIDTH-1:0]     freq_out;
    logic [PHASE_WIDTH-1:0]    phase_out;
    logic                      busy;
    logic                      done;
    logic                      overflow;

    modport master (
        output cmdstb, envstart, envlength, ampx, freqaddr, pini, mode,
        input  env_addr, env_valid, amp_out, freq_out, phase_out, busy, done, overflow
    );

    modport slave (
        input  cmdstb, envstart, envlength, ampx, freqaddr, pini, mode,
        output env_addr, env_valid, amp_out, freq_out, phase_out, busy, done, overflow
    );
endinterface

// File: rtl/elem_pulse_player.sv
// ----------------------------------------------------------------------------
// elem_pulse_player
// Accepts one pulse command and plays it out one sample per cycle: an envelope
// RAM address stream plus amp/freq/phase held for the whole pulse.
//   clk   : clock
//   reset : synchronous, active-high; aborts any pulse without a done
//   bus   : elem_pulse_player_if.slave (command in, playback stream out)
// Build option: define ELEM_PLAYER_QUEUE_EN for a 1-deep pending command slot;
// without it, commands arriving mid-pulse are dropped and flag overflow.
// ----------------------------------------------------------------------------
module elem_pulse_player #(
    parameter int unsigned ENV_ADDR_WIDTH = 12,
    parameter int unsigned AMP_WIDTH      = 16,
    parameter int unsigned FREQ_WIDTH     = 9,
    parameter int unsigned PHASE_WIDTH    = 17
) (
    input logic                clk,
    input logic                reset,
    elem_pulse_player_if.slave bus
);
    localparam logic [ENV_ADDR_WIDTH-1:0] AddrOne = ENV_ADDR_WIDTH'(1);

    typedef enum logic [0:0] {StIdle, StPlay} state_e;

    state_e                    r_state, w_state_d;
    logic [ENV_ADDR_WIDTH-1:0] r_addr, w_addr_d;
    logic [ENV_ADDR_WIDTH-1:0] r_remain, w_remain_d;  // samples left after the current one
    logic [1:0]                r_mode, w_mode_d;
    logic [AMP_WIDTH-1:0]      r_amp, w_amp_d;
    logic [FREQ_WIDTH-1:0]     r_freq, w_freq_d;
    logic [PHASE_WIDTH-1:0]    r_phase, w_phase_d;
    logic                      r_busy, w_busy_d;
    logic                      r_done, w_done_d;
    logic                      r_overflow, w_overflow_d;

    // Selected command source: pending slot has priority over the live strobe.
    logic                      w_src_valid;
    logic [ENV_ADDR_WIDTH-1:0] w_src_start, w_src_len;
    logic [1:0]                w_src_mode;
    logic [AMP_WIDTH-1:0]      w_src_amp;
    logic [FREQ_WIDTH-1:0]     w_src_freq;
    logic [PHASE_WIDTH-1:0]    w_src_phase;
    logic                      w_last, w_take;

`ifdef ELEM_PLAYER_QUEUE_EN
    logic                      r_pend_valid, w_pend_valid_d;
    logic [ENV_ADDR_WIDTH-1:0] r_pend_start, w_pend_start_d;
    logic [ENV_ADDR_WIDTH-1:0] r_pend_len, w_pend_len_d;
    logic [1:0]                r_pend_mode, w_pend_mode_d;
    logic [AMP_WIDTH-1:0]      r_pend_amp, w_pend_amp_d;
    logic [FREQ_WIDTH-1:0]     r_pend_freq, w_pend_freq_d;
    logic [PHASE_WIDTH-1:0]    r_pend_phase, w_pend_phase_d;
`endif

    always_comb begin
        w_src_valid = bus.cmdstb;
        w_src_start = bus.envstart;
        w_src_len   = bus.envlength;
        w_src_mode  = bus.mode;
        w_src_amp   = bus.ampx;
        w_src_freq  = bus.freqaddr;
        w_src_phase = bus.pini;
`ifdef ELEM_PLAYER_QUEUE_EN
        if (r_pend_valid) begin
            w_src_valid = 1'b1;
            w_src_start = r_pend_start;
            w_src_len   = r_pend_len;
            w_src_mode  = r_pend_mode;
            w_src_amp   = r_pend_amp;
            w_src_freq  = r_pend_freq;
            w_src_phase = r_pend_phase;
        end
`endif
    end

    assign w_last = (r_state == StPlay) && (r_remain == '0);
    // A new command may start whenever nothing is playing or the last sample is out.
    assign w_take = (r_state == StIdle) || w_last;

    always_comb begin
        w_state_d    = r_state;
        w_addr_d     = r_addr;
        w_remain_d   = r_remain;
        w_mode_d     = r_mode;
        w_amp_d      = r_amp;
        w_freq_d     = r_freq;
        w_phase_d    = r_phase;
        w_done_d     = 1'b0;
        w_overflow_d = r_overflow;
`ifdef ELEM_PLAYER_QUEUE_EN
        w_pend_valid_d = r_pend_valid;
        w_pend_start_d = r_pend_start;
        w_pend_len_d   = r_pend_len;
        w_pend_mode_d  = r_pend_mode;
        w_pend_amp_d   = r_pend_amp;
        w_pend_freq_d  = r_pend_freq;
        w_pend_phase_d = r_pend_phase;
`endif
        if (w_take) begin
            w_state_d  = StIdle;
            w_addr_d   = '0;
            w_remain_d = '0;
            w_amp_d    = '0;
            w_freq_d   = '0;
            w_phase_d  = '0;
            w_done_d   = w_last;
            if (w_src_valid) begin
                if (w_src_len != '0) begin
                    w_state_d  = StPlay;
                    w_addr_d   = (w_src_mode == 2'b10) ? w_src_start + w_src_len - AddrOne
                                                       : w_src_start;
                    w_remain_d = w_src_len - AddrOne;
                    w_mode_d   = w_src_mode;
                    w_amp_d    = w_src_amp;
                    w_freq_d   = w_src_freq;
                    w_phase_d  = w_src_phase;
                end else begin
                    // Empty pulse: no samples, just the completion strobe.
                    w_done_d = 1'b1;
                end
            end
`ifdef ELEM_PLAYER_QUEUE_EN
            // Slot drains into the player; a strobe arriving now refills it.
            if (r_pend_valid) begin
                w_pend_valid_d = bus.cmdstb;
                w_pend_start_d = bus.envstart;
                w_pend_len_d   = bus.envlength;
                w_pend_mode_d  = bus.mode;
                w_pend_amp_d   = bus.ampx;
                w_pend_freq_d  = bus.freqaddr;
                w_pend_phase_d = bus.pini;
            end
`endif
        end else begin
            w_remain_d = r_remain - AddrOne;
            unique case (r_mode)
                2'b01:   w_addr_d = r_addr;
                2'b10:   w_addr_d = r_addr - AddrOne;
                default: w_addr_d = r_addr + AddrOne;
            endcase
            if (bus.cmdstb) begin
`ifdef ELEM_PLAYER_QUEUE_EN
                if (r_pend_valid) begin
                    w_overflow_d = 1'b1;
                end else begin
                    w_pend_valid_d = 1'b1;
                    w_pend_start_d = bus.envstart;
                    w_pend_len_d   = bus.envlength;
                    w_pend_mode_d  = bus.mode;
                    w_pend_amp_d   = bus.ampx;
                    w_pend_freq_d  = bus.freqaddr;
                    w_pend_phase_d = bus.pini;
                end
`else
                w_overflow_d = 1'b1;
`endif
            end
        end
`ifdef ELEM_PLAYER_QUEUE_EN
        w_busy_d = (w_state_d == StPlay) || w_pend_valid_d;
`else
        w_busy_d = (w_state_d == StPlay);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= StIdle;
            r_addr     <= '0;
            r_remain   <= '0;
            r_mode     <= '0;
            r_amp      <= '0;
            r_freq     <= '0;
            r_phase    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_addr     <= w_addr_d;
            r_remain   <= w_remain_d;
            r_mode     <= w_mode_d;
            r_amp      <= w_amp_d;
            r_freq     <= w_freq_d;
            r_phase    <= w_phase_d;
            r_busy     <= w_busy_d;
            r_done     <= w_done_d;
            r_overflow <= w_overflow_d;
        end
    end

`ifdef ELEM_PLAYER_QUEUE_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend_valid <= 1'b0;
            r_pend_start <= '0;
            r_pend_len   <= '0;
            r_pend_mode  <= '0;
            r_pend_amp   <= '0;
            r_pend_freq  <= '0;
            r_pend_phase <= '0;
        end else begin
            r_pend_valid <= w_pend_valid_d;
            r_pend_start <= w_pend_start_d;
            r_pend_len   <= w_pend_len_d;
            r_pend_mode  <= w_pend_mode_d;
            r_pend_amp   <= w_pend_amp_d;
            r_pend_freq  <= w_pend_freq_d;
            r_pend_phase <= w_pend_phase_d;
        end
    end
`endif

    assign bus.env_addr  = r_addr;
    assign bus.env_valid = (r_state == StPlay);
    assign bus.amp_out   = r_amp;
    assign bus.freq_out  = r_freq;
    assign bus.phase_out = r_phase;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.overflow  = r_overflow;

endmodule

// File: tb/tb_elem_pulse_player.sv
// ----------------------------------------------------------------------------
// tb_elem_pulse_player
// Directed bench for elem_pulse_player. Inputs change 1ns after the rising
// edge; outputs are sampled at that same point, well away from the edge.
// Expectations depend on whether ELEM_PLAYER_QUEUE_EN is defined.
// ----------------------------------------------------------------------------
module tb_elem_pulse_player;
    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    elem_pulse_player_if bus ();

    elem_pulse_player dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        bus.cmdstb = 1'b0;
    endtask

    task automatic issue(input logic [11:0] s, input logic [11:0] len, input logic [1:0] m,
                         input logic [15:0] a, input logic [8:0] f, input logic [16:0] p);
        bus.cmdstb    = 1'b1;
        bus.envstart  = s;
        bus.envlength = len;
        bus.mode      = m;
        bus.ampx      = a;
        bus.freqaddr  = f;
        bus.pini      = p;
    endtask

    function automatic logic [11:0] exp_addr(input logic [11:0] s, input logic [11:0] len,
                                             input logic [1:0] m, input int k);
        logic [11:0] kk;
        kk = 12'(k);
        case (m)
            2'b01:   return s;
            2'b10:   return s + len - 12'd1 - kk;
            default: return s + kk;
        endcase
    endfunction

    task automatic check_sample(input string tag, input logic [11:0] addr, input logic [15:0] a,
                                input logic done);
        check_eq({tag, "_valid"}, 32'(bus.env_valid), 32'd1);
        check_eq({tag, "_addr"},  32'(bus.env_addr),  32'(addr));
        check_eq({tag, "_amp"},   32'(bus.amp_out),   32'(a));
        check_eq({tag, "_busy"},  32'(bus.busy),      32'd1);
        check_eq({tag, "_done"},  32'(bus.done),      32'(done));
    endtask

    task automatic check_idle_done(input string tag);
        check_eq({tag, "_done"},  32'(bus.done),      32'd1);
        check_eq({tag, "_valid"}, 32'(bus.env_valid), 32'd0);
        check_eq({tag, "_busy"},  32'(bus.busy),      32'd0);
        check_eq({tag, "_amp"},   32'(bus.amp_out),   32'd0);
        check_eq({tag, "_freq"},  32'(bus.freq_out),  32'd0);
        check_eq({tag, "_phase"}, 32'(bus.phase_out), 32'd0);
    endtask

    // Issue one command from idle and check every cycle through done.
    task automatic run_pulse(input string tag, input logic [11:0] s, input logic [11:0] len,
                             input logic [1:0] m, input logic [15:0] a);
        issue(s, len, m, a, 9'h0A3, 17'h1ABCD);
        next_cycle();
        for (int k = 0; k < int'(len); k++) begin
            check_sample($sformatf("%s_s%0d", tag, k), exp_addr(s, len, m, k), a, 1'b0);
            check_eq($sformatf("%s_s%0d_freq", tag, k),  32'(bus.freq_out),  32'h0A3);
            check_eq($sformatf("%s_s%0d_phase", tag, k), 32'(bus.phase_out), 32'h1ABCD);
            next_cycle();
        end
        check_idle_done({tag, "_end"});
        next_cycle();
        check_eq({tag, "_done_clr"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        n_vec         = 0;
        n_err         = 0;
        reset         = 1'b1;
        bus.cmdstb    = 1'b0;
        bus.envstart  = '0;
        bus.envlength = '0;
        bus.mode      = '0;
        bus.ampx      = '0;
        bus.freqaddr  = '0;
        bus.pini      = '0;
        repeat (3) next_cycle();
        reset = 1'b0;

        check_eq("rst_valid", 32'(bus.env_valid), 32'd0);
        check_eq("rst_addr",  32'(bus.env_addr),  32'd0);
        check_eq("rst_busy",  32'(bus.busy),      32'd0);
        check_eq("rst_done",  32'(bus.done),      32'd0);
        check_eq("rst_ovf",   32'(bus.overflow),  32'd0);
        check_eq("rst_amp",   32'(bus.amp_out),   32'd0);

        // Directed playback patterns, including wrap and mode 11 aliasing fwd.
        run_pulse("fwd",   12'h010, 12'd4, 2'b00, 16'h7FFF);
        run_pulse("rev",   12'h100, 12'd3, 2'b10, 16'h1234);
        run_pulse("hold",  12'h100, 12'd3, 2'b01, 16'h0F0F);
        run_pulse("wrap",  12'hFFE, 12'd4, 2'b00, 16'h8001);
        run_pulse("m11",   12'h020, 12'd2, 2'b11, 16'h0042);
        run_pulse("rwrap", 12'hFFF, 12'd3, 2'b10, 16'h0101);
        run_pulse("empty", 12'h055, 12'd0, 2'b00, 16'h5555);
        run_pulse("one",   12'hABC, 12'd1, 2'b10, 16'hFFFF);

        // Gapless: second command issued on the last-sample cycle of the first.
        issue(12'h200, 12'd3, 2'b00, 16'h1111, 9'h001, 17'h00001);
        next_cycle();
        check_sample("b2b_a0", 12'h200, 16'h1111, 1'b0);
        next_cycle();
        check_sample("b2b_a1", 12'h201, 16'h1111, 1'b0);
        next_cycle();
        check_sample("b2b_a2", 12'h202, 16'h1111, 1'b0);
        issue(12'h300, 12'd2, 2'b10, 16'h2222, 9'h002, 17'h00002);
        next_cycle();
        check_sample("b2b_b0", 12'h301, 16'h2222, 1'b1);
        check_eq("b2b_b0_freq", 32'(bus.freq_out), 32'h002);
        next_cycle();
        check_sample("b2b_b1", 12'h300, 16'h2222, 1'b0);
        next_cycle();
        check_idle_done("b2b_end");
        check_eq("b2b_ovf", 32'(bus.overflow), 32'd0);
        next_cycle();

        // Three commands in consecutive cycles, all length 8.
        issue(12'h400, 12'd8, 2'b00, 16'h0001, 9'h011, 17'h00011);
        next_cycle();
        check_sample("q_a0", 12'h400, 16'h0001, 1'b0);
        issue(12'h500, 12'd8, 2'b00, 16'h0002, 9'h022, 17'h00022);
        next_cycle();
        check_sample("q_a1", 12'h401, 16'h0001, 1'b0);
        issue(12'h600, 12'd8, 2'b00, 16'h0003, 9'h033, 17'h00033);
        next_cycle();
        check_eq("q_ovf", 32'(bus.overflow), 32'd1);
        for (int k = 2; k < 8; k++) begin
            check_sample($sformatf("q_a%0d", k), 12'h400 + 12'(k), 16'h0001, 1'b0);
            next_cycle();
        end
`ifdef ELEM_PLAYER_QUEUE_EN
        for (int k = 0; k < 8; k++) begin
            check_sample($sformatf("q_b%0d", k), 12'h500 + 12'(k), 16'h0002, k == 0);
            next_cycle();
        end
        check_idle_done("q_end");
`else
        check_idle_done("q_end");
`endif
        next_cycle();
        check_eq("q_ovf_sticky", 32'(bus.overflow), 32'd1);
        check_eq("q_quiet", 32'(bus.env_valid), 32'd0);

        // Reset while the second sample is showing aborts with no done.
        issue(12'h700, 12'd5, 2'b00, 16'h7777, 9'h077, 17'h00077);
        next_cycle();
        check_sample("rm_s0", 12'h700, 16'h7777, 1'b0);
        next_cycle();
        check_sample("rm_s1", 12'h701, 16'h7777, 1'b0);
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        check_eq("rm_valid", 32'(bus.env_valid), 32'd0);
        check_eq("rm_busy",  32'(bus.busy),      32'd0);
        check_eq("rm_done",  32'(bus.done),      32'd0);
        check_eq("rm_ovf",   32'(bus.overflow),  32'd0);
        check_eq("rm_amp",   32'(bus.amp_out),   32'd0);
        for (int k = 0; k < 6; k++) begin
            next_cycle();
            check_eq($sformatf("rm_nodone%0d", k), 32'(bus.done), 32'd0);
            check_eq($sformatf("rm_novalid%0d", k), 32'(bus.env_valid), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
